// File: rtl/ctrl_seq.sv
// One-hot pipeline sequencer: FETCH/DEC/RGRD/ALU/RGWR/MEM with stall, flush,
// memory-ready handshake with timeout, optional MEM stage and retire counter.
module ctrl_seq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16,
  parameter bit RGRD_IN_WB  = 1'b1
) (
  input  logic             I_clk,
  input  logic             I_reset_n,
  input  logic             I_stall,
  input  logic             I_flush,
  input  logic             I_memrdy,
  input  logic             I_needmem,
  output logic [5:0]       O_state,
  output logic             O_enfetch,
  output logic             O_endec,
  output logic             O_enrgrd,
  output logic             O_enalu,
  output logic             O_enrgwr,
  output logic             O_enmem,
  output logic             O_retire,
  output logic             O_timeout,
  output logic [CNT_W-1:0] O_instcnt
);

  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TO_EN = (MEM_TIMEOUT > 0);
  localparam logic [WW-1:0] LP_LIMIT = TO_EN ? WW'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [5:0] {
    S_FETCH = 6'b000001,
    S_DEC   = 6'b000010,
    S_RGRD  = 6'b000100,
    S_ALU   = 6'b001000,
    S_RGWR  = 6'b010000,
    S_MEM   = 6'b100000
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WW-1:0]    r_wait;
  logic [WW-1:0]    w_wait;
  logic             r_retire;
  logic             r_timeout;
  logic [CNT_W-1:0] r_instcnt;
  logic             w_retire;
  logic             w_timeout;
  logic             w_legal;
  logic             w_hit;

  assign w_legal = $onehot(r_state);
  // Timeout fires on the last permitted wait cycle; memory-ready takes precedence.
  assign w_hit   = TO_EN && !I_memrdy && (r_wait == LP_LIMIT);

  // State, wait counter, pulse and retire-count registers.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retire  <= 1'b0;
      r_timeout <= 1'b0;
      r_instcnt <= '0;
    end else begin
      r_state   <= w_next;
      r_wait    <= w_wait;
      r_retire  <= w_retire;
      r_timeout <= w_timeout;
      if (w_retire) begin
        r_instcnt <= r_instcnt + CNT_W'(1'b1);
      end
    end
  end

  // Next-state, wait-counter and pulse decode: illegal > flush > stall > normal.
  always_comb begin
    w_next    = r_state;
    w_wait    = r_wait;
    w_retire  = 1'b0;
    w_timeout = 1'b0;
    if (!w_legal) begin
      w_next = S_FETCH;
      w_wait = '0;
    end else if (I_flush) begin
      w_next = S_FETCH;
      w_wait = '0;
    end else if (I_stall) begin
      w_next = r_state;
      w_wait = r_wait;
    end else begin
      w_wait = '0;
      case (r_state)
        S_FETCH: begin
          if (I_memrdy) begin
            w_next = S_DEC;
          end else if (w_hit) begin
            w_next    = S_FETCH;
            w_timeout = 1'b1;
          end else begin
            w_wait = r_wait + WW'(1'b1);
          end
        end
        S_DEC:  w_next = S_RGRD;
        S_RGRD: w_next = S_ALU;
        S_ALU:  w_next = S_RGWR;
        S_RGWR: begin
          if (I_needmem) begin
            w_next = S_MEM;
          end else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end
        S_MEM: begin
          if (I_memrdy) begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end else if (w_hit) begin
            w_next    = S_FETCH;
            w_timeout = 1'b1;
          end else begin
            w_wait = r_wait + WW'(1'b1);
          end
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

  assign O_state   = r_state;
  assign O_enfetch = r_state[0];
  assign O_endec   = r_state[1];
  assign O_enrgrd  = r_state[2] | (r_state[4] & RGRD_IN_WB);
  assign O_enalu   = r_state[3];
  assign O_enrgwr  = r_state[4];
  assign O_enmem   = r_state[5];
  assign O_retire  = r_retire;
  assign O_timeout = r_timeout;
  assign O_instcnt = r_instcnt;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench: instance a uses defaults, instance b uses MEM_TIMEOUT=4,
// CNT_W=2, RGRD_IN_WB=0; both share the same stimulus.
module tb_ctrl_seq;

  logic I_clk, I_reset_n, I_stall, I_flush, I_memrdy, I_needmem;

  logic [5:0]  a_state, b_state;
  logic        a_enf, a_end, a_enr, a_ena, a_enw, a_enm, a_ret, a_to;
  logic        b_enf, b_end, b_enr, b_ena, b_enw, b_enm, b_ret, b_to;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  ctrl_seq u_a (
    .I_clk(I_clk), .I_reset_n(I_reset_n), .I_stall(I_stall), .I_flush(I_flush),
    .I_memrdy(I_memrdy), .I_needmem(I_needmem), .O_state(a_state),
    .O_enfetch(a_enf), .O_endec(a_end), .O_enrgrd(a_enr), .O_enalu(a_ena),
    .O_enrgwr(a_enw), .O_enmem(a_enm), .O_retire(a_ret), .O_timeout(a_to),
    .O_instcnt(a_cnt)
  );

  ctrl_seq #(.MEM_TIMEOUT(4), .CNT_W(2), .RGRD_IN_WB(1'b0)) u_b (
    .I_clk(I_clk), .I_reset_n(I_reset_n), .I_stall(I_stall), .I_flush(I_flush),
    .I_memrdy(I_memrdy), .I_needmem(I_needmem), .O_state(b_state),
    .O_enfetch(b_enf), .O_endec(b_end), .O_enrgrd(b_enr), .O_enalu(b_ena),
    .O_enrgwr(b_enw), .O_enmem(b_enm), .O_retire(b_ret), .O_timeout(b_to),
    .O_instcnt(b_cnt)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  logic [5:0] seq [5];
  logic [1:0] bexp [4];

  initial begin
    seq[0] = 6'h01; seq[1] = 6'h02; seq[2] = 6'h04; seq[3] = 6'h08; seq[4] = 6'h10;
    bexp[0] = 2'd2; bexp[1] = 2'd3; bexp[2] = 2'd0; bexp[3] = 2'd1;
    I_reset_n = 1'b0; I_stall = 1'b0; I_flush = 1'b0; I_memrdy = 1'b0; I_needmem = 1'b0;
    repeat (2) @(posedge I_clk);
    #1;
    // reset state
    chk("rst_state", {26'd0, a_state}, 32'h01);
    chk("rst_en", {26'd0, a_enm, a_enw, a_ena, a_enr, a_end, a_enf}, 32'h01);
    chk("rst_pulses", {30'd0, a_ret, a_to}, 32'd0);
    chk("rst_cnt", {16'd0, a_cnt}, 32'd0);

    // back-to-back instructions without MEM
    I_reset_n = 1'b1; I_memrdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 5; s++) begin
        chk("seq_state", {26'd0, a_state}, {26'd0, seq[s]});
        chk("seq_retire", {31'd0, a_ret}, {31'd0, (s == 0 && i > 0)});
        if (s == 2) chk("enrgrd_rgrd_b", {31'd0, b_enr}, 32'd1);
        if (s == 4) begin
          chk("enrgrd_wb_a", {31'd0, a_enr}, 32'd1);
          chk("enrgrd_wb_b", {31'd0, b_enr}, 32'd0);
        end
        tick();
      end
    end
    chk("seq3_state", {26'd0, a_state}, 32'h01);
    chk("seq3_retire", {31'd0, a_ret}, 32'd1);
    chk("seq3_cnt_a", {16'd0, a_cnt}, 32'd3);
    chk("seq3_cnt_b", {30'd0, b_cnt}, 32'd3);

    // MEM with three not-ready cycles
    for (int s = 0; s < 4; s++) tick();
    chk("mem_rgwr", {26'd0, a_state}, 32'h10);
    I_needmem = 1'b1; I_memrdy = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("mem_hold_a", {26'd0, a_state}, 32'h20);
      chk("mem_hold_b", {26'd0, b_state}, 32'h20);
      tick();
    end
    chk("mem_4th", {26'd0, b_state}, 32'h20);
    I_memrdy = 1'b1;
    tick();
    chk("mem_done_state", {26'd0, a_state}, 32'h01);
    chk("mem_done_ret", {31'd0, a_ret}, 32'd1);
    chk("mem_done_to", {30'd0, a_to, b_to}, 32'd0);
    chk("mem_cnt_a", {16'd0, a_cnt}, 32'd4);
    chk("mem_cnt_b_wrap", {30'd0, b_cnt}, 32'd0);

    // MEM timeout on instance b (limit 4)
    for (int s = 0; s < 4; s++) tick();
    chk("to_rgwr", {26'd0, b_state}, 32'h10);
    I_memrdy = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("to_mem", {26'd0, b_state}, 32'h20);
      chk("to_nopulse", {31'd0, b_to}, 32'd0);
      tick();
    end
    chk("to_fetch", {26'd0, b_state}, 32'h01);
    chk("to_pulse", {31'd0, b_to}, 32'd1);
    chk("to_noret", {31'd0, b_ret}, 32'd0);
    chk("to_cnt", {30'd0, b_cnt}, 32'd0);
    chk("to_a_still_mem", {26'd0, a_state}, 32'h20);
    tick();
    chk("to_pulse_end", {31'd0, b_to}, 32'd0);

    // resynchronise both instances
    I_reset_n = 1'b0; I_needmem = 1'b0; I_memrdy = 1'b1;
    tick();
    I_reset_n = 1'b1;

    // stall in ALU, then flush+stall in RGRD
    tick(); tick(); tick();
    chk("stall_alu", {26'd0, a_state}, 32'h08);
    I_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", {26'd0, a_state}, 32'h08);
    end
    I_stall = 1'b0;
    tick();
    chk("stall_go", {26'd0, a_state}, 32'h10);
    tick();
    chk("stall_ret", {31'd0, a_ret}, 32'd1);
    chk("stall_cnt", {16'd0, a_cnt}, 32'd1);
    tick(); tick();
    chk("flush_rgrd", {26'd0, a_state}, 32'h04);
    I_flush = 1'b1; I_stall = 1'b1;
    tick();
    I_flush = 1'b0; I_stall = 1'b0;
    chk("flush_state", {26'd0, a_state}, 32'h01);
    chk("flush_noret", {31'd0, a_ret}, 32'd0);
    chk("flush_cnt", {16'd0, a_cnt}, 32'd1);

    // 2-bit counter wrap sequence
    for (int j = 0; j < 4; j++) begin
      for (int s = 0; s < 5; s++) tick();
      chk("wrap_ret", {31'd0, b_ret}, 32'd1);
      chk("wrap_cnt", {30'd0, b_cnt}, {30'd0, bexp[j]});
    end

    // asynchronous reset mid-ALU
    tick(); tick(); tick();
    chk("arst_alu", {26'd0, a_state}, 32'h08);
    #2 I_reset_n = 1'b0;
    #1;
    chk("arst_state", {26'd0, a_state}, 32'h01);
    chk("arst_cnt", {16'd0, a_cnt}, 32'd0);
    chk("arst_fetch_en", {31'd0, b_enf}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Parametrised successor to the fixed 6-state one-hot pipeline sequencer of the 16-bit RISC core.
- Sequences FETCH/DEC/RGRD/ALU/RGWR/MEM and drives the per-stage enables.
- Adds stall, flush, memory-ready handshake with timeout, optional MEM skip and a retired-instruction counter.
- Sits between the core top level and the fetch, decode, regfile, ALU and memory blocks.

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory state waits for I_memrdy before abort; 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.
- RGRD_IN_WB, 1: 1 = O_enrgrd also asserted in RGWR; 0 = O_enrgrd only in RGRD.

Ports:
- I_clk  in  1  clock, rising edge.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_stall  in  1  hold the current state.
- I_flush  in  1  abandon the current instruction and return to FETCH.
- I_memrdy  in  1  memory handshake: access complete (used in FETCH and MEM).
- I_needmem  in  1  sampled in RGRWR: instruction needs the MEM stage.
- O_state  out  6  one-hot state: bit0 FETCH, 1 DEC, 2 RGRD, 3 ALU, 4 RGWR, 5 MEM.
- O_enfetch  out  1  equals state[0].
- O_endec  out  1  equals state[1].
- O_enrgrd  out  1  state[2] | (state[4] & RGRD_IN_WB).
- O_enalu  out  1  equals state[3].
- O_enrgwr  out  1  equals state[4].
- O_enmem  out  1  equals state[5].
- O_retire  out  1  one-cycle registered pulse: instruction retired.
- O_timeout  out  1  one-cycle registered pulse: memory wait aborted.
- O_instcnt  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.

Behaviour:
- Reset (I_reset_n low, asynchronous):
  - state = 000001 (FETCH), wait counter = 0, O_instcnt = 0, O_retire = 0, O_timeout = 0.
  - Enables follow state, so reset gives O_enfetch = 1 and all other enables 0.
  - Reset mid-instruction discards it without retire.
- Enables and O_state are combinational decodes of the state register. State is always exactly one-hot; any illegal encoding goes to FETCH on the next edge.
- Next-state priority per rising edge: flush > stall > normal transition.
- Flush:
  - Next state FETCH, wait counter cleared, no retire, no timeout.
  - A flush while already in FETCH restarts the FETCH wait.
- Stall: state, wait counter and all pulses hold (pulses forced 0).
- Normal transitions:
  - FETCH -> DEC when I_memrdy = 1; otherwise stay.
  - DEC -> RGRD -> ALU -> RGWR, one cycle each.
  - RGWR -> MEM if I_needmem = 1, else -> FETCH with retire.
  - MEM -> FETCH with retire when I_memrdy = 1; otherwise stay.
- Wait counter (width clog2(MEM_TIMEOUT+1), minimum 1 bit):
  - Counts cycles spent in FETCH/MEM with I_memrdy = 0.
  - Cleared on entry to any state.
  - I_memrdy has priority over timeout in the same cycle.
- Timeout: if MEM_TIMEOUT > 0, I_memrdy = 0 and counter = MEM_TIMEOUT - 1, then:
  - next state FETCH, O_timeout = 1 next cycle, no retire;
  - a timeout in FETCH also re-enters FETCH, with the counter cleared.
- Retire:
  - O_retire = 1 and O_instcnt + 1 in the cycle after the retiring edge, i.e. coincident with the first FETCH cycle.
  - 2^CNT_W - 1 wraps to 0.
- Minimum instruction latency: 5 cycles without MEM (FETCH with I_memrdy held 1), 6 with MEM.
- I_needmem, I_memrdy are ignored outside the states named above.

Test Plan:
- Reset release, I_memrdy = 1, I_needmem = 0 -> O_state 01,02,04,08,10,01; O_retire pulses every 5 cycles; O_instcnt = 3 after 15 cycles.
- I_needmem = 1, I_memrdy low for 3 MEM cycles then high -> MEM held 4 cycles, then FETCH, O_retire = 1, no O_timeout.
- MEM_TIMEOUT = 4, I_memrdy = 0 in MEM -> exactly 4 MEM cycles, then FETCH, O_timeout = 1 for one cycle, O_instcnt unchanged.
- I_stall high 3 cycles in ALU, and I_flush + I_stall together in RGRD -> stall holds state 08 for 3 cycles then proceeds; flush wins and goes to FETCH, no retire.
- RGRD_IN_WB = 0 vs 1 -> O_enrgrd high only in state 04, vs high in 04 and 10.
- CNT_W = 2, 5 retires; also I_reset_n low asynchronously mid-ALU -> O_instcnt 1,2,3,0,1; state = 01 immediately, without waiting for a clock edge.
